// File: rtl/winv_addr_sched.sv
// winv_addr_sched
// Read-address scheduler for the per-PE inverse-twiddle storage during an INTT.
// One instance feeds all PE storages in lockstep. A start pulse walks every
// stage and issues one address per butterfly slot. Issue freezes while stall
// is high, and a fixed drain gap is inserted between stages.
//
// state | meaning
// IDLE  | waiting for start, raddr forced to 0
// RUN   | issuing one address per non-stalled cycle
// GAP   | inter-stage drain, STAGE_GAP cycles, stall ignored
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     one-cycle start request, honoured only in IDLE
//   stall     datapath back-pressure, freezes issue in RUN
//   raddr     storage read address (storage has a 1-cycle registered read)
//   busy      sequence in progress, drops the cycle after done
//   tw_valid  storage dout this cycle is a fresh twiddle
//   tw_stage  stage index of the word flagged by tw_valid
//   tw_last   final twiddle of the final stage
//   done      one-cycle pulse, coincident with tw_last
module winv_addr_sched #(
   parameter int RING_DEPTH = 10,
   parameter int PE_DEPTH   = 5,
   parameter int HLEN       = 9,
   parameter int STAGE_GAP  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            stall,
   output logic [HLEN-1:0] raddr,
   output logic            busy,
   output logic            tw_valid,
   output logic [3:0]      tw_stage,
   output logic            tw_last,
   output logic            done
);

   localparam int L  = RING_DEPTH - PE_DEPTH;
   localparam int B  = 2 ** (L - 1);
   localparam int KW = (L > 1) ? (L - 1) : 1;
   localparam int GW = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;

   localparam logic [KW-1:0] K_LAST   = KW'(B - 1);
   localparam logic [3:0]    S_LAST   = 4'(RING_DEPTH - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'((STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      stage, stage_nxt;
   logic [KW-1:0]   k, k_nxt;
   logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
   logic            issue;
   logic            last_issue;
   logic [HLEN-1:0] addr_calc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         stage    <= '0;
         k        <= '0;
         gap_cnt  <= '0;
         tw_valid <= 1'b0;
         tw_stage <= '0;
         tw_last  <= 1'b0;
      end else begin
         state    <= state_nxt;
         stage    <= stage_nxt;
         k        <= k_nxt;
         gap_cnt  <= gap_cnt_nxt;
         tw_valid <= issue;
         tw_last  <= last_issue;
         if (issue)
            tw_stage <= stage;
      end
   end

   // stage/k are only advanced when leaving GAP, so raddr keeps showing the
   // last address of the finished stage for the whole drain gap.
   always_comb begin
      state_nxt   = state;
      stage_nxt   = stage;
      k_nxt       = k;
      gap_cnt_nxt = gap_cnt;
      issue       = 1'b0;
      last_issue  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               stage_nxt = '0;
               k_nxt     = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               issue = 1'b1;
               if (k == K_LAST) begin
                  if (stage == S_LAST) begin
                     last_issue = 1'b1;
                     state_nxt  = IDLE;
                  end else if (STAGE_GAP == 0) begin
                     stage_nxt = stage + 4'd1;
                     k_nxt     = '0;
                  end else begin
                     state_nxt   = GAP;
                     gap_cnt_nxt = GAP_LOAD;
                  end
               end else begin
                  k_nxt = k + KW'(1);
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = RUN;
               stage_nxt = stage + 4'd1;
               k_nxt     = '0;
            end else begin
               gap_cnt_nxt = gap_cnt - GW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Early stages hold 2^s twiddles shared by groups of 2^(L-1-s) slots;
   // later stages use a single twiddle each.
   always_comb begin
      addr_calc = '0;
      if (state != IDLE) begin
         if (stage < 4'(L))
            addr_calc = ((HLEN'(1) << stage) - HLEN'(1))
                      + (HLEN'(k) >> (4'(L - 1) - stage));
         else
            addr_calc = HLEN'((2 ** L) - 1) + HLEN'(stage - 4'(L));
      end
   end

   assign raddr = addr_calc;
   assign done  = tw_last;
   assign busy  = (state != IDLE) || tw_last;

endmodule

// File: tb/tb_winv_addr_sched.sv
// Bench for winv_addr_sched: a default instance (STAGE_GAP=4) and a
// STAGE_GAP=0 instance. Expected addresses come from the storage layout
// formula, and the timing reference is an issue-index/gap-countdown model.
module tb_winv_addr_sched;

   localparam int RD  = 10;
   localparam int PD  = 5;
   localparam int HL  = 9;
   localparam int GAP = 4;
   localparam int L   = RD - PD;
   localparam int B   = 2 ** (L - 1);
   localparam int NW  = RD * B;
   localparam int LAT0 = NW + (RD - 1) * GAP + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0, stall = 1'b0;
   logic [HL-1:0] raddr;
   logic          busy, tw_valid, tw_last, done;
   logic [3:0]    tw_stage;

   logic          start0 = 1'b0, stall0 = 1'b0;
   logic [HL-1:0] raddr0;
   logic          busy0, tw_valid0, tw_last0, done0;
   logic [3:0]    tw_stage0;

   int n_checks = 0;
   int n_pass   = 0;
   int addr_q[NW];
   int stage_q[NW];

   always #5 clk = ~clk;

   winv_addr_sched #(.RING_DEPTH(RD), .PE_DEPTH(PD), .HLEN(HL), .STAGE_GAP(GAP)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .raddr(raddr),
      .busy(busy), .tw_valid(tw_valid), .tw_stage(tw_stage), .tw_last(tw_last), .done(done));

   winv_addr_sched #(.RING_DEPTH(RD), .PE_DEPTH(PD), .HLEN(HL), .STAGE_GAP(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .stall(stall0), .raddr(raddr0),
      .busy(busy0), .tw_valid(tw_valid0), .tw_stage(tw_stage0), .tw_last(tw_last0), .done(done0));

   function automatic int exp_addr(int s, int k);
      if (s < L) return (2 ** s) - 1 + k / (2 ** (L - 1 - s));
      return (2 ** L) - 1 + (s - L);
   endfunction

   // Runs one sequence on the default instance, checking every cycle against
   // the reference; lat is the cycle of done counted from the start edge.
   task automatic run_seq(input int stall_pct, input int force_idx, input bit stall_gap,
                          input bit mid_start, input bit pre_started, input bit start_at_done,
                          output int lat, output int nrs);
      int idx, gap_left, cyc, fcnt, exp_r, paddr, pstage;
      bit active, pv, plast, st;
      logic [HL-1:0] prev_raddr;
      lat = -1;
      nrs = 0;
      if (!pre_started) begin
         start = 1'b1; stall = 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
      end
      active = 1; idx = 0; gap_left = 0; pv = 0; plast = 0; cyc = 1; fcnt = 0;
      paddr = 0; pstage = 0; prev_raddr = '0;
      while (cyc < 2000) begin
         exp_r = !active ? 0 : ((gap_left > 0) ? addr_q[idx-1] : addr_q[idx]);
         n_checks++;
         if (raddr !== HL'(exp_r)) $display("FAIL raddr cyc=%0d got=%0d exp=%0d", cyc, raddr, exp_r);
         else n_pass++;
         n_checks++;
         if (tw_valid !== pv) $display("FAIL tw_valid cyc=%0d got=%b exp=%b", cyc, tw_valid, pv);
         else n_pass++;
         n_checks++;
         if (busy !== (active || plast)) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, active || plast);
         else n_pass++;
         n_checks++;
         if (done !== (pv && plast)) $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, pv && plast);
         else n_pass++;
         if (pv) begin
            n_checks++;
            if (tw_stage !== 4'(pstage)) $display("FAIL tw_stage cyc=%0d got=%0d exp=%0d", cyc, tw_stage, pstage);
            else n_pass++;
            n_checks++;
            if (tw_last !== plast) $display("FAIL tw_last cyc=%0d got=%b exp=%b", cyc, tw_last, plast);
            else n_pass++;
            n_checks++;
            if (prev_raddr !== HL'(paddr)) $display("FAIL word_addr cyc=%0d got=%0d exp=%0d", cyc, prev_raddr, paddr);
            else n_pass++;
         end
         if (pv && plast) begin
            lat = cyc;
            break;
         end
         st = ($urandom_range(99) < stall_pct);
         if (stall_gap && gap_left > 0) st = 1'b1;
         if (active && gap_left == 0 && idx == force_idx && fcnt < 3) begin
            st = 1'b1;
            fcnt++;
         end
         stall = st;
         start = mid_start && (cyc == 50);
         prev_raddr = raddr;
         pv = 0; plast = 0;
         if (active) begin
            if (gap_left > 0) gap_left--;
            else if (st) nrs++;
            else begin
               pv = 1; paddr = addr_q[idx]; pstage = stage_q[idx]; plast = (idx == NW - 1);
               idx++;
               if (idx == NW) active = 0;
               else if (idx % B == 0) gap_left = GAP;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (lat < 0) begin
         n_checks++;
         $display("FAIL seq_timeout got=no_done exp=done within 2000 cycles");
      end
      stall = 1'b0;
      start = start_at_done;
      @(posedge clk); #1;
      start = 1'b0;
      if (!start_at_done) begin
         n_checks++;
         if (busy !== 1'b0 || tw_valid !== 1'b0 || raddr !== '0)
            $display("FAIL post_done got busy=%b vld=%b raddr=%0d exp=0/0/0", busy, tw_valid, raddr);
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (raddr !== '0 || busy !== 1'b0 || tw_valid !== 1'b0 || tw_stage !== '0 || tw_last !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_vals got raddr=%0d busy=%b vld=%b stg=%0d last=%b done=%b exp=all 0",
                  raddr, busy, tw_valid, tw_stage, tw_last, done);
      else n_pass++;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_nostall;
      int lat, nrs;
      run_seq(0, -1, 0, 0, 0, 0, lat, nrs);
      n_checks++;
      if (lat !== LAT0) $display("FAIL nostall_latency got=%0d exp=%0d", lat, LAT0);
      else n_pass++;
   endtask

   task automatic test_stall_burst;
      int lat, nrs;
      run_seq(0, 2 * B + 5, 0, 0, 0, 0, lat, nrs);
      n_checks++;
      if (lat !== LAT0 + 3) $display("FAIL stall_burst_latency got=%0d exp=%0d", lat, LAT0 + 3);
      else n_pass++;
   endtask

   task automatic test_stall_gap;
      int lat, nrs;
      run_seq(0, -1, 1, 0, 0, 0, lat, nrs);
      n_checks++;
      if (lat !== LAT0) $display("FAIL stall_gap_latency got=%0d exp=%0d", lat, LAT0);
      else n_pass++;
   endtask

   task automatic test_random_stall;
      int lat, nrs;
      for (int r = 0; r < 3; r++) begin
         run_seq(10 + 15 * r, -1, 0, 0, 0, 0, lat, nrs);
         n_checks++;
         if (lat !== LAT0 + nrs) $display("FAIL random_latency run=%0d got=%0d exp=%0d", r, lat, LAT0 + nrs);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      int lat, nrs;
      run_seq(0, -1, 0, 1, 0, 1, lat, nrs);
      n_checks++;
      if (lat !== LAT0) $display("FAIL midstart_latency got=%0d exp=%0d", lat, LAT0);
      else n_pass++;
      run_seq(0, -1, 0, 0, 1, 0, lat, nrs);
      n_checks++;
      if (lat !== LAT0) $display("FAIL restart_latency got=%0d exp=%0d", lat, LAT0);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int lat, nrs;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (64) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1 || raddr !== HL'(addr_q[3 * B + 4]))
         $display("FAIL pre_reset got busy=%b raddr=%0d exp=1/%0d", busy, raddr, addr_q[3 * B + 4]);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || tw_valid !== 1'b0 || raddr !== '0 || done !== 1'b0)
         $display("FAIL async_reset got busy=%b vld=%b raddr=%0d done=%b exp=0", busy, tw_valid, raddr, done);
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || tw_valid !== 1'b0)
         $display("FAIL post_reset got busy=%b vld=%b exp=0/0", busy, tw_valid);
      else n_pass++;
      run_seq(0, -1, 0, 0, 0, 0, lat, nrs);
      n_checks++;
      if (lat !== LAT0) $display("FAIL reset_rerun_latency got=%0d exp=%0d", lat, LAT0);
      else n_pass++;
   endtask

   task automatic test_gap0;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      for (int c = 1; c <= NW + 2; c++) begin
         if (c <= NW) begin
            n_checks++;
            if (raddr0 !== HL'(addr_q[c-1])) $display("FAIL gap0_raddr cyc=%0d got=%0d exp=%0d", c, raddr0, addr_q[c-1]);
            else n_pass++;
         end
         n_checks++;
         if (tw_valid0 !== (c >= 2 && c <= NW + 1))
            $display("FAIL gap0_valid cyc=%0d got=%b exp=%b", c, tw_valid0, (c >= 2 && c <= NW + 1));
         else n_pass++;
         n_checks++;
         if (done0 !== (c == NW + 1)) $display("FAIL gap0_done cyc=%0d got=%b exp=%b", c, done0, (c == NW + 1));
         else n_pass++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (busy0 !== 1'b0 || tw_last0 !== 1'b0 || tw_stage0 !== 4'(RD - 1))
         $display("FAIL gap0_end got busy=%b last=%b stg=%0d exp=0/0/%0d", busy0, tw_last0, tw_stage0, RD - 1);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin
         stage_q[i] = i / B;
         addr_q[i]  = exp_addr(i / B, i % B);
      end
      test_reset();
      test_nostall();
      test_stall_burst();
      test_stall_gap();
      test_random_stall();
      test_back_to_back();
      test_reset_mid();
      test_gap0();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
